// File: rtl/pkt_rx_checker_pkg.sv
// Shared header layout, error codes and types for the packet sender and pkt_rx_checker.
// Field offsets are derived from the port count, priority levels and maximum length.
package pkt_rx_checker_pkg;

    localparam int PORT_NUB_TOTAL  = 16;
    localparam int PRIORITY        = 8;
    localparam int DATA_LENGTH_MAX = 255;
    localparam int DATA_WIDTH_DEF  = 32;

    localparam int WIDTH_SEL       = $clog2(PORT_NUB_TOTAL);
    localparam int WIDTH_PRIORITY  = $clog2(PRIORITY);
    localparam int WIDTH_LENGTH    = $clog2(DATA_LENGTH_MAX + 1);
    localparam int WIDTH_SRC_FIELD = 16;

    // Header beat: dest at the bottom, then priority, length and the 16-bit source field.
    localparam int OFS_DEST  = 0;
    localparam int OFS_PRIO  = OFS_DEST + WIDTH_SEL;
    localparam int OFS_LEN   = OFS_PRIO + WIDTH_PRIORITY;
    localparam int OFS_SRC   = OFS_LEN + WIDTH_LENGTH;
    localparam int HDR_WIDTH = OFS_SRC + WIDTH_SRC_FIELD;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_DEST  = 3'd1;
    localparam logic [2:0] ERR_SHORT = 3'd2;
    localparam logic [2:0] ERR_LONG  = 3'd3;
    localparam logic [2:0] ERR_DATA  = 3'd4;
    localparam logic [2:0] ERR_PROTO = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } rx_state_t;

    // One packet-close or stray-beat report waiting to be pulsed on the outputs.
    typedef struct packed {
        logic                      vld;
        logic                      done;
        logic [2:0]                code;
        logic [WIDTH_SEL-1:0]      src;
        logic [WIDTH_PRIORITY-1:0] prio;
        logic [WIDTH_LENGTH-1:0]   len;
    } close_ev_t;

    function automatic logic [WIDTH_SEL+WIDTH_LENGTH-1:0] payload_word(
        input logic [WIDTH_SEL-1:0]    src,
        input logic [WIDTH_LENGTH-1:0] idx
    );
        return {src, idx};
    endfunction

endpackage

// File: rtl/pkt_rx_checker_hdr_decode.sv
// pkt_hdr_decode: purely combinational split of a header beat into its fields.
module pkt_hdr_decode
    import pkt_rx_checker_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
)(
    input  logic [DATA_WIDTH-1:0]     i_hdr,
    output logic [WIDTH_SEL-1:0]      o_dest,
    output logic [WIDTH_PRIORITY-1:0] o_prio,
    output logic [WIDTH_LENGTH-1:0]   o_len,
    output logic [WIDTH_SEL-1:0]      o_src
);

    assign o_dest = i_hdr[OFS_DEST +: WIDTH_SEL];
    assign o_prio = i_hdr[OFS_PRIO +: WIDTH_PRIORITY];
    assign o_len  = i_hdr[OFS_LEN  +: WIDTH_LENGTH];
    assign o_src  = i_hdr[OFS_SRC  +: WIDTH_SEL];

endmodule

// File: rtl/pkt_rx_checker.sv
// pkt_rx_checker: checks packets leaving one switch output port and keeps statistics.
// Define RX_CHECK_DATA_EN to enable the payload content compare (error code 4).
module pkt_rx_checker
    import pkt_rx_checker_pkg::*;
#(
    parameter int RX_PORT    = 0,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_sop,
    input  logic                      rd_eop,
    input  logic                      rd_vld,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    input  logic                      pause,
    input  logic                      clr,
    output logic                      ready,
    output logic                      pkt_done,
    output logic                      err,
    output logic [2:0]                err_code,
    output logic [15:0]               pkt_cnt,
    output logic [15:0]               err_cnt,
    output logic [WIDTH_SEL-1:0]      last_src,
    output logic [WIDTH_PRIORITY-1:0] last_prio,
    output logic [WIDTH_LENGTH-1:0]   last_len
);

    rx_state_t                 r_state, w_state_nxt;
    logic [WIDTH_LENGTH-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]                r_code, w_code_nxt;
    logic [WIDTH_SEL-1:0]      r_src, w_src_nxt;
    logic [WIDTH_PRIORITY-1:0] r_prio, w_prio_nxt;
    logic [WIDTH_LENGTH-1:0]   r_len, w_len_nxt;
    logic                      r_ready, r_pkt_done, r_err;
    logic [2:0]                r_err_code;
    logic [15:0]               r_pkt_cnt, r_err_cnt;
    logic [WIDTH_SEL-1:0]      r_last_src;
    logic [WIDTH_PRIORITY-1:0] r_last_prio;
    logic [WIDTH_LENGTH-1:0]   r_last_len;
    close_ev_t                 r_hold, w_hold_nxt, w_emit, w_ev0, w_ev1;
    logic                      w_open_hdr;
    logic [2:0]                w_beat_code, w_hdr_code, w_hdr_close_code;
    logic [WIDTH_SEL-1:0]      w_hdr_dest, w_hdr_src;
    logic [WIDTH_PRIORITY-1:0] w_hdr_prio;
    logic [WIDTH_LENGTH-1:0]   w_hdr_len;

    pkt_hdr_decode #(.DATA_WIDTH(DATA_WIDTH)) u_hdr_decode (
        .i_hdr  (rd_data),
        .o_dest (w_hdr_dest),
        .o_prio (w_hdr_prio),
        .o_len  (w_hdr_len),
        .o_src  (w_hdr_src)
    );

    function automatic close_ev_t mk_ev(
        input logic                      done,
        input logic [2:0]                code,
        input logic [WIDTH_SEL-1:0]      src,
        input logic [WIDTH_PRIORITY-1:0] prio,
        input logic [WIDTH_LENGTH-1:0]   len
    );
        close_ev_t ev;
        ev.vld  = 1'b1;
        ev.done = done;
        ev.code = code;
        ev.src  = src;
        ev.prio = prio;
        ev.len  = len;
        return ev;
    endfunction

    // A wrong destination is reported ahead of a beat taken while not ready.
    always_comb begin
        w_hdr_code = ERR_NONE;
        if (w_hdr_dest != WIDTH_SEL'(RX_PORT)) begin
            w_hdr_code = ERR_DEST;
        end else if (!r_ready) begin
            w_hdr_code = ERR_PROTO;
        end
        w_hdr_close_code = w_hdr_code;
        if (w_hdr_code == ERR_NONE && w_hdr_len != '0) begin
            w_hdr_close_code = ERR_SHORT;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_src_nxt   = r_src;
        w_prio_nxt  = r_prio;
        w_len_nxt   = r_len;
        w_ev0       = '0;
        w_ev1       = '0;
        w_open_hdr  = 1'b0;
        w_beat_code = r_code;
        case (r_state)
            ST_IDLE: begin
                if (rd_vld) begin
                    if (rd_sop) begin
                        w_open_hdr = 1'b1;
                    end else begin
                        w_ev0 = mk_ev(1'b0, ERR_PROTO, r_src, r_prio, r_len);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rd_vld) begin
                    if (rd_sop) begin
                        w_ev0 = mk_ev(1'b1, (r_code != ERR_NONE) ? r_code : ERR_PROTO,
                                      r_src, r_prio, r_len);
                        w_open_hdr = 1'b1;
                    end else begin
                        if (w_beat_code == ERR_NONE && !r_ready) begin
                            w_beat_code = ERR_PROTO;
                        end
                        if (r_cnt >= r_len) begin
                            if (w_beat_code == ERR_NONE) begin
                                w_beat_code = ERR_LONG;
                            end
                            if (rd_eop) begin
                                w_ev0       = mk_ev(1'b1, w_beat_code, r_src, r_prio, r_len);
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_code_nxt  = w_beat_code;
                                w_state_nxt = ST_DROP;
                            end
                        end else begin
`ifdef RX_CHECK_DATA_EN
                            if (w_beat_code == ERR_NONE &&
                                rd_data != DATA_WIDTH'(payload_word(r_src, r_cnt))) begin
                                w_beat_code = ERR_DATA;
                            end
`endif
                            if (rd_eop) begin
                                if (w_beat_code == ERR_NONE &&
                                    (r_cnt + WIDTH_LENGTH'(1)) != r_len) begin
                                    w_beat_code = ERR_SHORT;
                                end
                                w_ev0       = mk_ev(1'b1, w_beat_code, r_src, r_prio, r_len);
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_cnt_nxt  = r_cnt + WIDTH_LENGTH'(1);
                                w_code_nxt = w_beat_code;
                            end
                        end
                    end
                end
            end
            ST_DROP: begin
                if (rd_vld) begin
                    if (rd_sop) begin
                        w_ev0      = mk_ev(1'b1, r_code, r_src, r_prio, r_len);
                        w_open_hdr = 1'b1;
                    end else if (rd_eop) begin
                        w_ev0       = mk_ev(1'b1, r_code, r_src, r_prio, r_len);
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A header seen mid-packet may itself be a single-beat packet; it then becomes the second event.
        if (w_open_hdr) begin
            w_src_nxt  = w_hdr_src;
            w_prio_nxt = w_hdr_prio;
            w_len_nxt  = w_hdr_len;
            w_cnt_nxt  = '0;
            w_code_nxt = w_hdr_code;
            if (rd_eop) begin
                w_state_nxt = ST_IDLE;
                if (w_ev0.vld) begin
                    w_ev1 = mk_ev(1'b1, w_hdr_close_code, w_hdr_src, w_hdr_prio, w_hdr_len);
                end else begin
                    w_ev0 = mk_ev(1'b1, w_hdr_close_code, w_hdr_src, w_hdr_prio, w_hdr_len);
                end
            end else begin
                w_state_nxt = ST_PAYLOAD;
            end
        end
    end

    // Two events can only coincide when the checker is mid-packet, so one hold slot always drains.
    always_comb begin
        w_emit     = r_hold.vld ? r_hold : w_ev0;
        w_hold_nxt = r_hold.vld ? w_ev0 : w_ev1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_code  <= ERR_NONE;
            r_src   <= '0;
            r_prio  <= '0;
            r_len   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_code  <= w_code_nxt;
            r_src   <= w_src_nxt;
            r_prio  <= w_prio_nxt;
            r_len   <= w_len_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready     <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_pkt_cnt   <= '0;
            r_err_cnt   <= '0;
            r_last_src  <= '0;
            r_last_prio <= '0;
            r_last_len  <= '0;
        end else begin
            r_ready    <= ~pause;
            r_pkt_done <= w_emit.vld & w_emit.done;
            r_err      <= w_emit.vld & (w_emit.code != ERR_NONE);
            r_err_code <= w_emit.vld ? w_emit.code : ERR_NONE;
            if (clr) begin
                r_pkt_cnt <= '0;
            end else if (w_emit.vld && w_emit.done && r_pkt_cnt != 16'hFFFF) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (clr) begin
                r_err_cnt <= '0;
            end else if (w_emit.vld && w_emit.code != ERR_NONE && r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (clr) begin
                r_last_src  <= '0;
                r_last_prio <= '0;
                r_last_len  <= '0;
            end else if (w_emit.vld && w_emit.done && w_emit.code == ERR_NONE) begin
                r_last_src  <= w_emit.src;
                r_last_prio <= w_emit.prio;
                r_last_len  <= w_emit.len;
            end
        end
    end

    assign ready     = r_ready;
    assign pkt_done  = r_pkt_done;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign pkt_cnt   = r_pkt_cnt;
    assign err_cnt   = r_err_cnt;
    assign last_src  = r_last_src;
    assign last_prio = r_last_prio;
    assign last_len  = r_last_len;

endmodule
